// File: rtl/bus_pkg.sv
// Shared bus-source definitions for the bus-grant arbiter and the select encoder.
// Pure declarations: no latency, no flow control.
package bus_pkg;

    localparam int NUM_BUS_SRC = 24;
    localparam int GRANT_W     = 32;

    localparam logic [4:0] SRC_R0     = 5'd0;
    localparam logic [4:0] SRC_R1     = 5'd1;
    localparam logic [4:0] SRC_R2     = 5'd2;
    localparam logic [4:0] SRC_R3     = 5'd3;
    localparam logic [4:0] SRC_R4     = 5'd4;
    localparam logic [4:0] SRC_R5     = 5'd5;
    localparam logic [4:0] SRC_R6     = 5'd6;
    localparam logic [4:0] SRC_R7     = 5'd7;
    localparam logic [4:0] SRC_R8     = 5'd8;
    localparam logic [4:0] SRC_R9     = 5'd9;
    localparam logic [4:0] SRC_R10    = 5'd10;
    localparam logic [4:0] SRC_R11    = 5'd11;
    localparam logic [4:0] SRC_R12    = 5'd12;
    localparam logic [4:0] SRC_R13    = 5'd13;
    localparam logic [4:0] SRC_R14    = 5'd14;
    localparam logic [4:0] SRC_R15    = 5'd15;
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHI    = 5'd18;
    localparam logic [4:0] SRC_ZLO    = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_C      = 5'd23;

    // Encoder output when no grant bit is set: bus left undriven.
    localparam logic [4:0] BUS_SEL_NONE = 5'd31;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between bus sources and the arbiter.
// Level-sensitive requests, registered grant; no backpressure.
interface bus_grant_arbiter_if #(
    parameter int NUM_SRC = 24,
    parameter int GRANT_W = 32
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] lock;
    logic [GRANT_W-1:0] grant;
    logic               busy;
    logic               handover;

    modport master (
        output req,
        output lock,
        input  grant,
        input  busy,
        input  handover
    );

    modport slave (
        input  req,
        input  lock,
        output grant,
        output busy,
        output handover
    );
endinterface

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Rotating priority find: first set candidate at or after ptr, wrapping at NUM_SRC.
// Purely combinational, zero latency; no flow control.
module rr_pick #(
    parameter int NUM_SRC = 24
) (
    input  logic [NUM_SRC-1:0] cand_i,
    input  logic [4:0]         ptr_i,
    output logic               vld_o,
    output logic [4:0]         idx_o
);
    logic [5:0] pos;

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pos = {1'b0, ptr_i} + 6'(i);
            if (pos >= 6'(NUM_SRC)) begin
                pos = pos - 6'(NUM_SRC);
            end
            if (!vld_o && cand_i[pos[4:0]]) begin
                vld_o = 1'b1;
                idx_o = pos[4:0];
            end
        end
    end
endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter with lock/hold limit, feeding the 32-to-5 select encoder.
// Request-to-grant latency 1 cycle; grants are registered one-hot, no backpressure.
module bus_grant_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_SRC  = NUM_BUS_SRC,
    parameter int GRANT_W  = bus_pkg::GRANT_W,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 clear_n,
    bus_grant_arbiter_if.slave   bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [4:0] LAST_SRC = 5'(NUM_SRC - 1);

    arb_state_e          state_q;
    logic [4:0]          owner_q;
    logic [4:0]          ptr_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [GRANT_W-1:0]  grant_q;
    logic                handover_q;

    logic [NUM_SRC-1:0]  owner_bit;
    logic [NUM_SRC-1:0]  cand;
    logic [4:0]          pick_ptr;
    logic                pick_vld;
    logic [4:0]          pick_idx;
    logic                owner_req;
    logic                keep;
    logic [4:0]          ptr_d;
    logic [4:0]          owner_ptr_d;
    logic [GRANT_W-1:0]  grant_d;

    function automatic logic [4:0] wrap_inc(input logic [4:0] v);
        return (v == LAST_SRC) ? 5'd0 : v + 5'd1;
    endfunction

    assign owner_bit   = NUM_SRC'(1) << owner_q;
    assign owner_req   = bus.req[owner_q];
    assign owner_ptr_d = wrap_inc(owner_q);

    // While owned, the current owner is excluded and the search starts just after it.
    assign cand     = (state_q == OWNED) ? (bus.req & ~owner_bit) : bus.req;
    assign pick_ptr = (state_q == OWNED) ? owner_ptr_d : ptr_q;

    assign keep = (state_q == OWNED) && owner_req && bus.lock[owner_q]
                  && (hold_cnt_q < HOLD_W'(MAX_HOLD));

    assign ptr_d   = wrap_inc(pick_idx);
    assign grant_d = GRANT_W'(1) << pick_idx;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .cand_i (cand),
        .ptr_i  (pick_ptr),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            handover_q <= 1'b0;
        end else begin
            handover_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q    <= OWNED;
                        owner_q    <= pick_idx;
                        ptr_q      <= ptr_d;
                        hold_cnt_q <= HOLD_W'(1);
                        grant_q    <= grant_d;
                        handover_q <= 1'b1;
                    end
                end
                OWNED: begin
                    if (keep) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end else if (pick_vld) begin
                        owner_q    <= pick_idx;
                        ptr_q      <= ptr_d;
                        hold_cnt_q <= HOLD_W'(1);
                        grant_q    <= grant_d;
                        handover_q <= 1'b1;
                    end else if (owner_req) begin
                        // Sole requester keeps the bus but its hold window restarts.
                        ptr_q      <= owner_ptr_d;
                        hold_cnt_q <= HOLD_W'(1);
                    end else begin
                        state_q    <= IDLE;
                        hold_cnt_q <= '0;
                        grant_q    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = |grant_q;
    assign bus.handover = handover_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed checks of reset, round-robin order, lock/hold limit and withdrawal.
module tb_bus_grant_arbiter;
    import bus_pkg::*;

    logic clock;
    logic clear_n;
    int   n_vec;
    int   n_err;

    bus_grant_arbiter_if #(.NUM_SRC(24), .GRANT_W(32)) bus ();

    bus_grant_arbiter #(
        .NUM_SRC  (24),
        .GRANT_W  (32),
        .MAX_HOLD (8)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [31:0] g);
        for (int i = 0; i < 24; i++) begin
            if (g[i]) return 32'(i);
        end
        return 32'(BUS_SEL_NONE);
    endfunction

    function automatic logic [23:0] bit24(input logic [4:0] idx);
        return 24'(1) << idx;
    endfunction

    logic [31:0] exp_rr [5];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        clear_n = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        exp_rr[0] = 32'h0000_0008;
        exp_rr[1] = 32'h0010_0000;
        exp_rr[2] = 32'h0080_0000;
        exp_rr[3] = 32'h0000_0008;
        exp_rr[4] = 32'h0010_0000;

        // Reset state
        #2;
        chk("rst_grant",    bus.grant, 32'h0);
        chk("rst_busy",     32'(bus.busy), 32'h0);
        chk("rst_handover", 32'(bus.handover), 32'h0);
        chk("rst_hold",     32'(dut.hold_cnt_q), 32'h0);
        chk("rst_ptr",      32'(dut.ptr_q), 32'h0);
        #5 clear_n = 1'b1;

        // Single unlocked request on R4
        tick();
        bus.req = bit24(SRC_R4);
        tick();
        chk("single_grant",    bus.grant, 32'h0000_0010);
        chk("single_handover", 32'(bus.handover), 32'h1);
        chk("single_busy",     32'(bus.busy), 32'h1);
        chk("single_hold",     32'(dut.hold_cnt_q), 32'h1);
        chk("single_enc",      enc(bus.grant), 32'd4);
        tick();
        chk("single_grant2",    bus.grant, 32'h0000_0010);
        chk("single_handover2", 32'(bus.handover), 32'h0);
        chk("single_hold2",     32'(dut.hold_cnt_q), 32'h1);
        tick();
        chk("single_hold3",     32'(dut.hold_cnt_q), 32'h1);
        bus.req = '0;
        tick();
        chk("single_release", bus.grant, 32'h0);
        chk("single_rel_busy", 32'(bus.busy), 32'h0);

        // Reset mid-ownership drops the grant without a clock edge
        bus.req  = bit24(SRC_R0);
        bus.lock = bit24(SRC_R0);
        tick();
        chk("midrst_owned", bus.grant, 32'h0000_0001);
        #3 clear_n = 1'b0;
        #1;
        chk("midrst_grant",    bus.grant, 32'h0);
        chk("midrst_busy",     32'(bus.busy), 32'h0);
        chk("midrst_handover", 32'(bus.handover), 32'h0);
        #1 clear_n = 1'b1;
        bus.req  = bit24(SRC_R5);
        bus.lock = '0;
        tick();
        chk("midrst_r5",    bus.grant, 32'h0000_0020);
        chk("midrst_r5_ho", 32'(bus.handover), 32'h1);
        bus.req = '0;
        tick();
        chk("midrst_idle", bus.grant, 32'h0);
        clear_n = 1'b0;
        #1 clear_n = 1'b1;
        chk("ptr_cleared", 32'(dut.ptr_q), 32'h0);

        // Round-robin across R3, PC, C with no idle cycles
        bus.req = bit24(SRC_R3) | bit24(SRC_PC) | bit24(SRC_C);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_grant%0d", k), bus.grant, exp_rr[k]);
            chk($sformatf("rr_ho%0d", k), 32'(bus.handover), 32'h1);
        end
        bus.req = '0;
        tick();
        chk("rr_idle", bus.grant, 32'h0);

        // Locked MDR held for MAX_HOLD cycles, then forced over to HI
        bus.req  = bit24(SRC_MDR);
        bus.lock = bit24(SRC_MDR);
        tick();
        chk("lock_mdr",      bus.grant, 32'h0020_0000);
        chk("lock_mdr_hold", 32'(dut.hold_cnt_q), 32'h1);
        bus.req = bit24(SRC_MDR) | bit24(SRC_HI);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("lock_mdr_c%0d", k), bus.grant, 32'h0020_0000);
            chk($sformatf("lock_hold_c%0d", k), 32'(dut.hold_cnt_q), 32'(k));
        end
        tick();
        chk("lock_hi",    bus.grant, 32'h0001_0000);
        chk("lock_hi_ho", 32'(bus.handover), 32'h1);
        bus.req  = '0;
        bus.lock = '0;
        tick();
        chk("lock_idle", bus.grant, 32'h0);

        // Locked PC alone: grant never drops, hold window restarts every 8 cycles
        bus.req  = bit24(SRC_PC);
        bus.lock = bit24(SRC_PC);
        tick();
        chk("alone_pc", bus.grant, 32'h0010_0000);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("alone_grant%0d", k), bus.grant, 32'h0010_0000);
            chk($sformatf("alone_ho%0d", k), 32'(bus.handover), 32'h0);
            chk($sformatf("alone_hold%0d", k), 32'(dut.hold_cnt_q), 32'((k % 8) + 1));
        end

        // Lock without req is ignored: PC withdraws, R15 locked takes over
        bus.req  = bit24(SRC_R15);
        bus.lock = bit24(SRC_R15) | bit24(SRC_PC);
        tick();
        chk("wd_r15",    bus.grant, 32'h0000_8000);
        chk("wd_r15_ho", 32'(bus.handover), 32'h1);
        tick();
        chk("wd_r15_hold", 32'(dut.hold_cnt_q), 32'h2);
        bus.req  = '0;
        bus.lock = '0;
        #2;
        chk("wd_still_owned", bus.grant, 32'h0000_8000);
        tick();
        chk("wd_grant", bus.grant, 32'h0);
        chk("wd_busy",  32'(bus.busy), 32'h0);
        chk("wd_ho",    32'(bus.handover), 32'h0);
        chk("wd_enc",   enc(bus.grant), 32'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
